// File: rtl/sync_fifo_cfg.sv
// Single-clock FIFO with a selectable registered or first-word-fall-through read port,
// registered threshold flags, occupancy count, sticky error flags and a synchronous flush.
module sync_fifo_cfg #(
  parameter int WIDTH         = 8,
  parameter int DEPTH         = 16,
  parameter int PTR_WIDTH     = 4,
  parameter int FWFT          = 0,
  parameter int AFULL_THRESH  = 12,
  parameter int AEMPTY_THRESH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clear,
  input  logic                 write_en,
  input  logic [WIDTH-1:0]     wdata,
  input  logic                 read_en,
  output logic [WIDTH-1:0]     rdata,
  output logic                 full,
  output logic                 empty,
  output logic                 almost_full,
  output logic                 almost_empty,
  output logic [PTR_WIDTH:0]   count,
  output logic                 overflow,
  output logic                 underflow
);

  localparam logic [PTR_WIDTH:0] DEPTH_C  = (PTR_WIDTH+1)'(DEPTH);
  localparam logic [PTR_WIDTH:0] AFULL_C  = (PTR_WIDTH+1)'(AFULL_THRESH);
  localparam logic [PTR_WIDTH:0] AEMPTY_C = (PTR_WIDTH+1)'(AEMPTY_THRESH);
  localparam logic [PTR_WIDTH:0] ONE_C    = {{PTR_WIDTH{1'b0}}, 1'b1};

  logic [WIDTH-1:0]   mem [DEPTH];
  logic [PTR_WIDTH:0] wr_ptr;
  logic [PTR_WIDTH:0] rd_ptr;
  logic [PTR_WIDTH:0] wr_next;
  logic [PTR_WIDTH:0] rd_next;
  logic [PTR_WIDTH:0] count_next;
  logic               wr_acc;
  logic               rd_acc;

  // clear wins over both requests, so neither is accepted in a flush cycle
  always_comb begin
    wr_acc     = write_en && !full && !clear;
    rd_acc     = read_en && !empty && !clear;
    wr_next    = wr_ptr + {{PTR_WIDTH{1'b0}}, wr_acc};
    rd_next    = rd_ptr + {{PTR_WIDTH{1'b0}}, rd_acc};
    count_next = count;
    if (clear)
      count_next = '0;
    else if (wr_acc && !rd_acc)
      count_next = count + ONE_C;
    else if (rd_acc && !wr_acc)
      count_next = count - ONE_C;
  end

  always_ff @(posedge clk) begin
    if (wr_acc)
      mem[wr_ptr[PTR_WIDTH-1:0]] <= wdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      full         <= 1'b0;
      empty        <= 1'b1;
      almost_full  <= 1'b0;
      almost_empty <= 1'b1;
      overflow     <= 1'b0;
      underflow    <= 1'b0;
    end else begin
      wr_ptr       <= clear ? '0 : wr_next;
      rd_ptr       <= clear ? '0 : rd_next;
      count        <= count_next;
      full         <= (count_next == DEPTH_C);
      empty        <= (count_next == '0);
      almost_full  <= (count_next >= AFULL_C);
      almost_empty <= (count_next <= AEMPTY_C);
      overflow     <= !clear && (overflow  || (write_en && full));
      underflow    <= !clear && (underflow || (read_en && empty));
    end
  end

  // In FWFT mode rdata is preloaded with the next head; when that head is being
  // written this very cycle the memory still holds stale data, so bypass wdata.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata <= '0;
    end else if (FWFT == 0) begin
      if (rd_acc)
        rdata <= mem[rd_ptr[PTR_WIDTH-1:0]];
    end else if (count_next != '0) begin
      if (wr_acc && (wr_ptr == rd_next))
        rdata <= wdata;
      else
        rdata <= mem[rd_next[PTR_WIDTH-1:0]];
    end
  end

endmodule

// File: tb/tb_sync_fifo_cfg.sv
// Directed bench: a registered-read and an FWFT instance share stimulus; a vector
// table covers fill/drain/clear, hand sequences cover the multi-cycle corners.
module tb_sync_fifo_cfg;

  logic       clk = 1'b0;
  logic       rst, clear, write_en, read_en;
  logic [7:0] wdata;

  logic [7:0] rdata0, rdata1;
  logic       full0, empty0, af0, ae0, ovf0, udf0;
  logic       full1, empty1, af1, ae1, ovf1, udf1;
  logic [4:0] count0, count1;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  sync_fifo_cfg #(.WIDTH(8), .DEPTH(16), .PTR_WIDTH(4), .FWFT(0),
                  .AFULL_THRESH(12), .AEMPTY_THRESH(4)) dut0 (
    .clk(clk), .rst(rst), .clear(clear), .write_en(write_en), .wdata(wdata),
    .read_en(read_en), .rdata(rdata0), .full(full0), .empty(empty0),
    .almost_full(af0), .almost_empty(ae0), .count(count0),
    .overflow(ovf0), .underflow(udf0));

  sync_fifo_cfg #(.WIDTH(8), .DEPTH(16), .PTR_WIDTH(4), .FWFT(1),
                  .AFULL_THRESH(12), .AEMPTY_THRESH(4)) dut1 (
    .clk(clk), .rst(rst), .clear(clear), .write_en(write_en), .wdata(wdata),
    .read_en(read_en), .rdata(rdata1), .full(full1), .empty(empty1),
    .almost_full(af1), .almost_empty(ae1), .count(count1),
    .overflow(ovf1), .underflow(udf1));

  typedef struct {
    logic       we;
    logic [7:0] wd;
    logic       re;
    logic       clr;
    logic [4:0] c;
    logic       e, f, af, ae, ov, un;
    logic [7:0] rd;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // one clock: drive, take the edge, settle 1ns, return inputs to idle
  task automatic cyc(input logic we, input logic [7:0] wd, input logic re, input logic clr);
    write_en = we; wdata = wd; read_en = re; clear = clr;
    @(posedge clk);
    #1;
    write_en = 1'b0; read_en = 1'b0; clear = 1'b0;
  endtask

  function automatic vec_t mk(input logic we, input logic [7:0] wd, input logic re,
                              input logic clr, input int c, input logic ov,
                              input logic un, input logic [7:0] rd);
    vec_t v;
    v.we = we; v.wd = wd; v.re = re; v.clr = clr;
    v.c  = 5'(c);
    v.e  = (c == 0);
    v.f  = (c == 16);
    v.af = (c >= 12);
    v.ae = (c <= 4);
    v.ov = ov; v.un = un; v.rd = rd;
    return v;
  endfunction

  logic [7:0] q[$];
  logic [7:0] exp_rd0;
  logic       we_r, re_r, we_ok, re_ok;
  logic [7:0] wd_r;

  initial begin
    rst = 1'b1; clear = 1'b0; write_en = 1'b0; read_en = 1'b0; wdata = 8'h00;

    // fill 0x00..0x0F, one overflowing write, drain, one underflowing read, clear
    for (int i = 0; i < 16; i++) tbl.push_back(mk(1, 8'(i), 0, 0, i + 1, 0, 0, 8'h00));
    tbl.push_back(mk(1, 8'hFF, 0, 0, 16, 1, 0, 8'h00));
    for (int i = 0; i < 16; i++) tbl.push_back(mk(0, 8'h00, 1, 0, 15 - i, 1, 0, 8'(i)));
    tbl.push_back(mk(0, 8'h00, 1, 0, 0, 1, 1, 8'h0F));
    tbl.push_back(mk(1, 8'h99, 1, 1, 0, 0, 0, 8'h0F));

    @(posedge clk); #1;
    chk("rst_count", count0, 0);
    chk("rst_empty", empty0, 1);
    chk("rst_aempty", ae0, 1);
    chk("rst_full", full0, 0);
    chk("rst_afull", af0, 0);
    chk("rst_ovf", ovf0, 0);
    chk("rst_udf", udf0, 0);
    chk("rst_rdata", rdata0, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < tbl.size(); i++) begin
      cyc(tbl[i].we, tbl[i].wd, tbl[i].re, tbl[i].clr);
      chk($sformatf("v%0d_count", i), count0, tbl[i].c);
      chk($sformatf("v%0d_empty", i), empty0, tbl[i].e);
      chk($sformatf("v%0d_full", i), full0, tbl[i].f);
      chk($sformatf("v%0d_afull", i), af0, tbl[i].af);
      chk($sformatf("v%0d_aempty", i), ae0, tbl[i].ae);
      chk($sformatf("v%0d_ovf", i), ovf0, tbl[i].ov);
      chk($sformatf("v%0d_udf", i), udf0, tbl[i].un);
      chk($sformatf("v%0d_rdata", i), rdata0, tbl[i].rd);
    end

    // simultaneous read/write at count=5
    for (int i = 0; i < 5; i++) cyc(1, 8'(8'h10 + i), 0, 0);
    chk("sim5_pre_count", count0, 5);
    cyc(1, 8'h15, 1, 0);
    chk("sim5_count", count0, 5);
    chk("sim5_rdata", rdata0, 8'h10);
    for (int i = 0; i < 5; i++) begin
      cyc(0, 8'h00, 1, 0);
      chk($sformatf("sim5_drain%0d", i), rdata0, 8'(8'h11 + i));
    end
    chk("sim5_empty", empty0, 1);

    // simultaneous at full
    for (int i = 0; i < 16; i++) cyc(1, 8'(8'h20 + i), 0, 0);
    chk("simf_pre_full", full0, 1);
    cyc(1, 8'hEE, 1, 0);
    chk("simf_count", count0, 15);
    chk("simf_ovf", ovf0, 1);
    chk("simf_full", full0, 0);
    chk("simf_rdata", rdata0, 8'h20);
    cyc(0, 8'h00, 0, 1);

    // simultaneous at empty
    cyc(1, 8'h77, 1, 0);
    chk("sime_count", count0, 1);
    chk("sime_udf", udf0, 1);
    chk("sime_empty", empty0, 0);
    chk("sime_rdata", rdata0, 8'h20);
    chk("sime_fwft_rdata", rdata1, 8'h77);
    cyc(0, 8'h00, 0, 1);
    chk("sime_clr_fwft_hold", rdata1, 8'h77);

    // FWFT: data falls through without read_en
    cyc(1, 8'hA5, 0, 0);
    chk("fwft_empty", empty1, 0);
    chk("fwft_rdata", rdata1, 8'hA5);
    cyc(0, 8'h00, 0, 0);
    chk("fwft_hold", rdata1, 8'hA5);
    cyc(0, 8'h00, 1, 0);
    chk("fwft_pop_empty", empty1, 1);
    chk("fwft_pop_count", count1, 0);
    chk("fwft_pop_hold", rdata1, 8'hA5);
    cyc(1, 8'hB1, 0, 0);
    cyc(1, 8'hB2, 0, 0);
    chk("fwft_head1", rdata1, 8'hB1);
    cyc(0, 8'h00, 1, 0);
    chk("fwft_head2", rdata1, 8'hB2);
    cyc(0, 8'h00, 1, 0);
    chk("fwft_end_empty", empty1, 1);
    chk("fwft_end_hold", rdata1, 8'hB2);

    // random interleave across the pointer wrap against a queue model
    exp_rd0 = 8'hB2;
    for (int k = 0; k < 40; k++) begin
      we_r = (k < 24) ? ($urandom_range(0, 9) < 8) : ($urandom_range(0, 9) < 3);
      re_r = ($urandom_range(0, 9) < 5);
      wd_r = 8'($urandom);
      we_ok = we_r && (q.size() < 16);
      re_ok = re_r && (q.size() > 0);
      cyc(we_r, wd_r, re_r, 0);
      if (re_ok) exp_rd0 = q.pop_front();
      if (we_ok) q.push_back(wd_r);
      chk($sformatf("wrap%0d_count", k), count0, q.size());
      chk($sformatf("wrap%0d_le16", k), count0 <= 5'd16, 1);
      chk($sformatf("wrap%0d_rdata", k), rdata0, exp_rd0);
      if (q.size() > 0) chk($sformatf("wrap%0d_fwft", k), rdata1, q[0]);
    end
    cyc(0, 8'h00, 0, 1);

    // clear mid-operation with overflow set, together with a write
    for (int i = 0; i < 17; i++) cyc(1, 8'(8'h40 + i), 0, 0);
    for (int i = 0; i < 7; i++) cyc(0, 8'h00, 1, 0);
    chk("clr_pre_count", count0, 9);
    chk("clr_pre_ovf", ovf0, 1);
    cyc(1, 8'hEE, 0, 1);
    chk("clr_count", count0, 0);
    chk("clr_empty", empty0, 1);
    chk("clr_ovf", ovf0, 0);
    chk("clr_rdata_hold", rdata0, 8'h46);
    cyc(0, 8'h00, 0, 0);
    chk("clr_discard_count", count0, 0);
    cyc(1, 8'h5A, 0, 0);
    cyc(0, 8'h00, 1, 0);
    chk("clr_after_rdata", rdata0, 8'h5A);

    // asynchronous reset between edges
    for (int i = 0; i < 3; i++) cyc(1, 8'(8'h61 + i), 0, 0);
    cyc(1, 8'h64, 1, 0);
    chk("arst_pre_count", count0, 3);
    #2 rst = 1'b1;
    #1;
    chk("arst_count", count0, 0);
    chk("arst_empty", empty0, 1);
    chk("arst_aempty", ae0, 1);
    chk("arst_rdata0", rdata0, 0);
    chk("arst_rdata1", rdata1, 0);
    chk("arst_fwft_empty", empty1, 1);
    #1 rst = 1'b0;
    @(posedge clk); #1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
